// File: rtl/mem_line_master.sv
// Single-port SRAM initiator that moves one cache line per request: a line fill
// (READ) or a dirty eviction (WRITE), one word per cycle, with Moore-decoded strobes.
module mem_line_master #(
  parameter int ADR_WIDTH      = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int OFF_WIDTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic                          req_write,
  input  logic [ADR_WIDTH-OFF_WIDTH-1:0] req_line_addr,
  output logic                          req_ready,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wdata_ready,
  output logic [OFF_WIDTH-1:0]          wdata_idx,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rdata_valid,
  output logic [OFF_WIDTH-1:0]          rdata_idx,
  output logic                          done,
  output logic                          mem_sel,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [ADR_WIDTH-1:0]          mem_address,
  output logic [DATA_WIDTH-1:0]         mem_datain,
  input  logic [DATA_WIDTH-1:0]         mem_dataout,
  output logic [1:0]                    dbg_state
);

  // Request handshake: a request is taken on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE, so requests while busy are simply not taken.
  localparam int LINE_WIDTH = ADR_WIDTH - OFF_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [OFF_WIDTH-1:0] CNT_LAST = OFF_WIDTH'(WORDS_PER_LINE - 1);

  logic [1:0]            state_q, state_d;
  logic [OFF_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic [OFF_WIDTH-1:0]  rdata_idx_q, rdata_idx_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    line_d        = line_q;
    rdata_d       = rdata_q;
    rdata_idx_d   = rdata_idx_q;
    rdata_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          line_d  = req_line_addr;
          cnt_d   = '0;
          state_d = req_write ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        // mem_dataout is only sampled here, so Z outside READ never reaches rdata.
        rdata_d       = mem_dataout;
        rdata_idx_d   = cnt_q;
        rdata_valid_d = 1'b1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      line_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_q        <= line_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_idx_q   <= rdata_idx_d;
    end
  end

  // Strobes decode from state alone, so an async reset drops them immediately.
  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    wdata_idx   = '0;
    done        = 1'b0;
    mem_sel     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_address = '0;
    mem_datain  = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_READ: begin
        mem_sel     = 1'b1;
        mem_rd      = 1'b1;
        mem_address = {line_q, cnt_q};
      end
      S_WRITE: begin
        mem_sel     = 1'b1;
        mem_wr      = 1'b1;
        mem_address = {line_q, cnt_q};
        wdata_ready = 1'b1;
        wdata_idx   = cnt_q;
        mem_datain  = wdata;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata_idx   = rdata_idx_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Bench for mem_line_master: SRAM and cache models, a table of line transfers,
// randomized transfers against a word-level memory model, and multi-cycle corner sequences.
module tb_mem_line_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [5:0]  req_line_addr;
  logic        req_ready;
  logic [15:0] wdata;
  logic        wdata_ready;
  logic [1:0]  wdata_idx;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic [1:0]  rdata_idx;
  logic        done;
  logic        mem_sel, mem_rd, mem_wr;
  logic [7:0]  mem_address;
  logic [15:0] mem_datain;
  wire  [15:0] mem_dataout;
  logic [1:0]  dbg_state;

  mem_line_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_line_addr(req_line_addr),
    .req_ready(req_ready),
    .wdata(wdata), .wdata_ready(wdata_ready), .wdata_idx(wdata_idx),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_idx(rdata_idx),
    .done(done),
    .mem_sel(mem_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // SRAM: async read when selected for read, write on posedge.
  logic [15:0] mem [256];
  assign mem_dataout = (mem_sel && mem_rd) ? mem[mem_address] : 16'hzzzz;
  always @(posedge clk) if (mem_sel && mem_wr) mem[mem_address] <= mem_datain;

  // Cache side: word k of the evicted line is base + k.
  logic [15:0] wpat_base;
  assign wdata = wpat_base + {14'd0, wdata_idx};

  // Reference model: what memory should hold, word by word.
  logic [15:0] ref_mem [256];

  int n_pass = 0;
  int n_total = 0;
  int viol = 0;

  always @(negedge clk) begin
    if ((mem_rd && mem_wr) || ((mem_rd || mem_wr) && !mem_sel)) viol++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct packed {
    logic        ready, sel, rd, wr;
    logic [7:0]  addr;
    logic        wrdy;
    logic [1:0]  widx;
    logic [15:0] datain;
    logic        done, rvalid;
  } obs_t;

  function automatic obs_t sample();
    obs_t o;
    o.ready = req_ready; o.sel = mem_sel; o.rd = mem_rd; o.wr = mem_wr;
    o.addr = mem_address; o.wrdy = wdata_ready; o.widx = wdata_idx;
    o.datain = mem_datain; o.done = done; o.rvalid = rdata_valid;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic run_xfer(input logic wr, input logic [5:0] line, input logic [15:0] base,
                          output logic [7:0] first_a, output logic [7:0] last_a);
    logic [15:0] exp_q[$];
    obs_t e;
    first_a = '0;
    last_a  = '0;
    wpat_base = base;
    if (!wr) for (int k = 0; k < 4; k++) exp_q.push_back(ref_mem[{line, 2'(k)}]);
    req_valid = 1'b1; req_write = wr; req_line_addr = line;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_line_addr = 6'($urandom);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      e = '0;
      if (cyc <= 4) begin
        e.sel = 1'b1; e.rd = !wr; e.wr = wr;
        e.addr = {line, 2'(cyc - 1)};
        if (wr) begin
          e.wrdy = 1'b1; e.widx = 2'(cyc - 1); e.datain = base + 16'(cyc - 1);
        end
      end
      if (cyc == 1) first_a = mem_address;
      if (cyc == 4) last_a = mem_address;
      if (cyc == 5) e.done = 1'b1;
      if (!wr && cyc >= 2 && cyc <= 5) e.rvalid = 1'b1;
      if (cyc == 6) e.ready = 1'b1;
      check($sformatf("xfer_cycle%0d", cyc), 64'(sample()), 64'(e));
      if (e.rvalid && exp_q.size() > 0)
        check("rdata_word", {46'd0, rdata_idx, rdata}, {46'd0, 2'(cyc - 2), exp_q.pop_front()});
    end
    if (wr) for (int k = 0; k < 4; k++) ref_mem[{line, 2'(k)}] = base + 16'(k);
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  line;
    logic [15:0] base;
    logic [7:0]  first_a;
    logic [7:0]  last_a;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fa, la;
    int accepts, dones, errs;
    logic [15:0] r;

    vecs[0] = '{1'b0, 6'h05, 16'h0000, 8'h14, 8'h17};
    vecs[1] = '{1'b1, 6'h3F, 16'hBEE0, 8'hFC, 8'hFF};
    vecs[2] = '{1'b0, 6'h3F, 16'h0000, 8'hFC, 8'hFF};
    vecs[3] = '{1'b1, 6'h00, 16'h1230, 8'h00, 8'h03};
    vecs[4] = '{1'b0, 6'h00, 16'h0000, 8'h00, 8'h03};

    for (int i = 0; i < 256; i++) begin
      r = 16'($urandom);
      mem[i] = r;
      ref_mem[i] = r;
    end
    for (int k = 0; k < 4; k++) begin
      mem[8'h14 + k] = 16'hA000 + 16'(k);
      ref_mem[8'h14 + k] = 16'hA000 + 16'(k);
    end
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_line_addr = '0; wpat_base = '0;

    // Reset during idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'(sample()), 64'(idle_obs()));
    check("reset_rdata", {46'd0, rdata_idx, rdata}, 64'd0);

    // Table: fill, eviction of the top line, read it back, then line 0.
    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].wr, vecs[i].line, vecs[i].base, fa, la);
      check($sformatf("vec%0d_addr_range", i), {48'd0, fa, la}, {48'd0, vecs[i].first_a, vecs[i].last_a});
    end
    for (int k = 0; k < 4; k++)
      check("top_line_written", 64'(mem[8'hFC + k]), 64'(16'hBEE0 + 16'(k)));

    // Async reset pulse while idle clears the held read word.
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    check("idle_reset_outputs", 64'(sample()), 64'(idle_obs()));
    check("idle_reset_rdata", {46'd0, rdata_idx, rdata}, 64'd0);

    // req_valid held high: one transfer per acceptance, next only from IDLE.
    accepts = 0; dones = 0;
    req_valid = 1'b1; req_write = 1'b0; req_line_addr = 6'h05;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) accepts++;
      if (done) begin
        dones++;
        check("held_done_cycle", 64'(i % 6), 64'd5);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("held_accepts", 64'(accepts), 64'd2);
    check("held_dones", 64'(dones), 64'd2);
    @(negedge clk);
    check("held_back_idle", 64'(sample()), 64'(idle_obs()));

    // Reset mid-eviction of line 0x02 after two words.
    for (int k = 0; k < 4; k++) begin
      mem[8'h08 + k] = 16'h5500 + 16'(k);
      ref_mem[8'h08 + k] = 16'h5500 + 16'(k);
    end
    wpat_base = 16'hC0C0;
    req_valid = 1'b1; req_write = 1'b1; req_line_addr = 6'h02;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midreset_strobes", {61'd0, mem_sel, mem_wr, mem_rd}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midreset_no_done", 64'(dones), 64'd0);
    check("midreset_idle", 64'(sample()), 64'(idle_obs()));
    check("midreset_mem", {mem[8'h08], mem[8'h09], mem[8'h0A], mem[8'h0B]},
          {16'hC0C0, 16'hC0C1, 16'h5502, 16'h5503});
    ref_mem[8'h08] = 16'hC0C0;
    ref_mem[8'h09] = 16'hC0C1;

    // Randomized transfers against the word-level model.
    for (int i = 0; i < 24; i++)
      run_xfer(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 16'($urandom), fa, la);

    errs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) errs++;
    check("final_memory_image", 64'(errs), 64'd0);
    check("strobe_protocol", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
